// File: rtl/helios_syndrome_ingress_pkg.sv
`default_nettype none
// ============================================================================
// Module      : helios_syndrome_ingress_pkg
// Description : Round geometry shared by the Helios ingress front-end and
//               the unified controller. Provides the ceil-div and max helpers
//               and the derived ROUND_BITS / BEATS / U_BIT_WIDTH values, so
//               both sides compute identical round shapes from the grid
//               parameters.
// Revision    : 1.0 - initial release
// ============================================================================
package helios_syndrome_ingress_pkg;

    // Default decoding-grid geometry.
    localparam int DEFAULT_GRID_WIDTH_X = 4;
    localparam int DEFAULT_GRID_WIDTH_Z = 1;
    localparam int DEFAULT_GRID_WIDTH_U = 3;

    // Pipeline stage identifier width used by the controller.
    localparam int STAGE_WIDTH = 3;

    function automatic int ceil_div(input int num, input int den);
        return (num + den - 1) / den;
    endfunction

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    // Measurement bits in one round.
    function automatic int round_bits(input int grid_x, input int grid_z);
        return grid_x * grid_z;
    endfunction

    // Host beats needed to carry one round.
    function automatic int beats(input int rbits, input int io_width);
        return ceil_div(rbits, io_width);
    endfunction

    // Width of the round-within-frame index (at least one bit).
    function automatic int u_bit_width(input int grid_u);
        return max_int(1, $clog2(grid_u));
    endfunction

endpackage
`default_nettype wire

// File: rtl/helios_syndrome_ingress_round_fifo.sv
`default_nettype none
// ============================================================================
// Module      : helios_syndrome_ingress_round_fifo
// Description : Round buffer with registered read. The head entry lives in
//               an output register; older entries wait in a circular
//               storage array. A push into an empty buffer loads the output
//               register directly, so it becomes visible on the next cycle.
// Ports       : clk, reset      - clock, synchronous active-high reset
//               push, push_data - write request and payload
//               pop             - read request (ignored while empty)
//               pop_data        - registered head entry
//               full, empty     - status, full derived from occupancy
//               occupancy       - entries currently held (0..DEPTH)
// Revision    : 1.0 - initial release
// ============================================================================
module helios_syndrome_ingress_round_fifo
    import helios_syndrome_ingress_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         pop_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   occupancy
);

    localparam int c_PTR_W = max_int(1, $clog2(DEPTH));
    localparam int c_CNT_W = $clog2(DEPTH) + 1;

    logic [WIDTH-1:0]   r_mem [DEPTH];
    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [c_PTR_W-1:0] r_rd_ptr;
    logic [c_CNT_W-1:0] r_count;
    logic [WIDTH-1:0]   r_dout;
    logic               r_valid;

    logic [c_CNT_W-1:0] w_mem_cnt;
    logic               w_full;
    logic               w_do_push;
    logic               w_do_pop;
    logic               w_load;
    logic               w_load_mem;
    logic               w_load_direct;
    logic               w_mem_write;

    // Entries sitting in the array, i.e. excluding the output register.
    assign w_mem_cnt     = r_count - c_CNT_W'(r_valid);
    assign w_full        = (r_count == c_CNT_W'(DEPTH));
    assign w_do_push     = push && !w_full;
    assign w_do_pop      = pop && r_valid;
    // The output register needs a new head when it is empty or being popped.
    assign w_load        = !r_valid || w_do_pop;
    assign w_load_mem    = w_load && (w_mem_cnt != '0);
    assign w_load_direct = w_load && (w_mem_cnt == '0) && w_do_push;
    assign w_mem_write   = w_do_push && !w_load_direct;

    // Storage needs no reset: an entry is only read after it was written.
    always_ff @(posedge clk) begin
        if (w_mem_write) begin
            r_mem[r_wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_dout   <= '0;
            r_valid  <= 1'b0;
        end else begin
            if (w_mem_write) begin
                r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
            end

            if (w_load_mem) begin
                r_dout   <= r_mem[r_rd_ptr];
                r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
                r_valid  <= 1'b1;
            end else if (w_load_direct) begin
                r_dout  <= push_data;
                r_valid <= 1'b1;
            end else if (w_load) begin
                // Nothing to show: data keeps its last value.
                r_valid <= 1'b0;
            end

            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + c_CNT_W'(1);
                2'b01:   r_count <= r_count - c_CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    assign pop_data  = r_dout;
    assign full      = w_full;
    assign empty     = !r_valid;
    assign occupancy = r_count;

endmodule
`default_nettype wire

// File: rtl/helios_syndrome_ingress.sv
`default_nettype none
// ============================================================================
// Module      : helios_syndrome_ingress
// Description : Helios decoder input front-end. Assembles IO_WIDTH-bit host
//               beats (LSB first) into GRID_WIDTH_X*GRID_WIDTH_Z-bit rounds,
//               tags each round with its index inside the GRID_WIDTH_U-round
//               frame, buffers up to FIFO_DEPTH rounds and counts frames.
// Ports       : clk, reset                 - clock, sync active-high reset
//               input_data/valid/ready     - host beat stream
//               flush                      - drop partial round, restart frame
//               round_data/index/last      - head-of-buffer round
//               round_valid/ready          - round handshake
//               frame_count                - completed frames (mod 2^16)
//               occupancy                  - rounds buffered
// Revision    : 1.0 - initial release
// ============================================================================
module helios_syndrome_ingress
    import helios_syndrome_ingress_pkg::*;
#(
    parameter int GRID_WIDTH_X = DEFAULT_GRID_WIDTH_X,
    parameter int GRID_WIDTH_Z = DEFAULT_GRID_WIDTH_Z,
    parameter int GRID_WIDTH_U = DEFAULT_GRID_WIDTH_U,
    parameter int IO_WIDTH     = 8,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                                      clk,
    input  logic                                      reset,
    input  logic [IO_WIDTH-1:0]                       input_data,
    input  logic                                      input_valid,
    output logic                                      input_ready,
    input  logic                                      flush,
    output logic [GRID_WIDTH_X*GRID_WIDTH_Z-1:0]      round_data,
    output logic [u_bit_width(GRID_WIDTH_U)-1:0]      round_index,
    output logic                                      round_last,
    output logic                                      round_valid,
    input  logic                                      round_ready,
    output logic [15:0]                               frame_count,
    output logic [$clog2(FIFO_DEPTH):0]               occupancy
);

    localparam int c_ROUND_BITS  = round_bits(GRID_WIDTH_X, GRID_WIDTH_Z);
    localparam int c_BEATS       = beats(c_ROUND_BITS, IO_WIDTH);
    localparam int c_U_BIT_WIDTH = u_bit_width(GRID_WIDTH_U);
    localparam int c_BEAT_W      = max_int(1, $clog2(c_BEATS));
    localparam int c_ENTRY_W     = 1 + c_U_BIT_WIDTH + c_ROUND_BITS;

    localparam logic [c_BEAT_W-1:0]      c_LAST_BEAT  = c_BEAT_W'(c_BEATS - 1);
    localparam logic [c_U_BIT_WIDTH-1:0] c_LAST_ROUND = c_U_BIT_WIDTH'(GRID_WIDTH_U - 1);

    logic [c_BEAT_W-1:0]      r_beat_cnt;
    logic [c_U_BIT_WIDTH-1:0] r_round_cnt;
    logic [c_ROUND_BITS-1:0]  r_asm;
    logic [15:0]              r_frame_count;

    logic [c_ROUND_BITS-1:0]  w_next_asm;
    logic                     w_beat_last;
    logic                     w_round_last;
    logic                     w_accept;
    logic                     w_push;
    logic [c_ENTRY_W-1:0]     w_push_entry;
    logic [c_ENTRY_W-1:0]     w_head_entry;
    logic                     w_fifo_full;
    logic                     w_fifo_empty;
    // Input bits that fall past ROUND_BITS in the final beat are discarded.
    logic                     w_unused_data;

    assign w_unused_data = ^input_data;

    assign w_beat_last  = (r_beat_cnt == c_LAST_BEAT);
    assign w_round_last = (r_round_cnt == c_LAST_ROUND);

    // Only a final beat can be blocked; readiness looks at registered
    // occupancy so a same-cycle pop frees space only from the next cycle.
    assign input_ready  = !(w_beat_last && w_fifo_full);
    assign w_accept     = input_valid && input_ready && !flush;
    assign w_push       = w_accept && w_beat_last;

    // Each round bit is owned by exactly one beat; the current beat's bits
    // come straight from the input so the final beat can be pushed at once.
    for (genvar j = 0; j < c_ROUND_BITS; j++) begin : g_asm
        localparam int c_BEAT = j / IO_WIDTH;
        localparam int c_BIT  = j % IO_WIDTH;
        assign w_next_asm[j] = (r_beat_cnt == c_BEAT_W'(c_BEAT)) ? input_data[c_BIT] : r_asm[j];
    end

    assign w_push_entry = {w_round_last, r_round_cnt, w_next_asm};

    always_ff @(posedge clk) begin
        if (reset) begin
            r_beat_cnt    <= '0;
            r_round_cnt   <= '0;
            r_asm         <= '0;
            r_frame_count <= '0;
        end else if (flush) begin
            r_beat_cnt  <= '0;
            r_round_cnt <= '0;
        end else if (w_accept) begin
            r_asm <= w_next_asm;
            if (w_beat_last) begin
                r_beat_cnt <= '0;
                if (w_round_last) begin
                    r_round_cnt   <= '0;
                    r_frame_count <= r_frame_count + 16'd1;
                end else begin
                    r_round_cnt <= r_round_cnt + c_U_BIT_WIDTH'(1);
                end
            end else begin
                r_beat_cnt <= r_beat_cnt + c_BEAT_W'(1);
            end
        end
    end

    helios_syndrome_ingress_round_fifo #(
        .WIDTH (c_ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_round_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (w_push),
        .push_data (w_push_entry),
        .pop       (round_ready),
        .pop_data  (w_head_entry),
        .full      (w_fifo_full),
        .empty     (w_fifo_empty),
        .occupancy (occupancy)
    );

    assign round_data  = w_head_entry[c_ROUND_BITS-1:0];
    assign round_index = w_head_entry[c_ROUND_BITS +: c_U_BIT_WIDTH];
    assign round_last  = w_head_entry[c_ENTRY_W-1];
    assign round_valid = !w_fifo_empty;
    assign frame_count = r_frame_count;

endmodule
`default_nettype wire

// File: tb/tb_helios_syndrome_ingress.sv
`default_nettype none
// ============================================================================
// Module      : tb_helios_syndrome_ingress
// Description : Self-checking bench for helios_syndrome_ingress in a
//               multi-beat geometry (8-bit rounds over 3-bit beats, partial
//               final beat). A queue-based model of rounds predicts every
//               output each cycle; directed sequences cover the documented
//               examples before randomized traffic.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_helios_syndrome_ingress;

    localparam int GX    = 4;
    localparam int GZ    = 2;
    localparam int GU    = 3;
    localparam int IOW   = 3;
    localparam int DEPTH = 4;
    localparam int RB    = GX * GZ;
    localparam int NB    = (RB + IOW - 1) / IOW;
    localparam int UW    = 2;
    localparam int OW    = 3;

    logic            clk;
    logic            reset;
    logic [IOW-1:0]  input_data;
    logic            input_valid;
    logic            input_ready;
    logic            flush;
    logic [RB-1:0]   round_data;
    logic [UW-1:0]   round_index;
    logic            round_last;
    logic            round_valid;
    logic            round_ready;
    logic [15:0]     frame_count;
    logic [OW-1:0]   occupancy;

    helios_syndrome_ingress #(
        .GRID_WIDTH_X (GX),
        .GRID_WIDTH_Z (GZ),
        .GRID_WIDTH_U (GU),
        .IO_WIDTH     (IOW),
        .FIFO_DEPTH   (DEPTH)
    ) u_dut (
        .clk         (clk),
        .reset       (reset),
        .input_data  (input_data),
        .input_valid (input_valid),
        .input_ready (input_ready),
        .flush       (flush),
        .round_data  (round_data),
        .round_index (round_index),
        .round_last  (round_last),
        .round_valid (round_valid),
        .round_ready (round_ready),
        .frame_count (frame_count),
        .occupancy   (occupancy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: rounds as integers in a queue.
    int m_beat  = 0;
    int m_rpos  = 0;
    int m_acc   = 0;
    int m_frames = 0;
    int m_q_data[$];
    int m_q_idx[$];
    int m_show_data = 0;
    int m_show_idx  = 0;
    bit m_known = 1'b0;

    task automatic check_eq(input string tag, input longint actual, input longint expected);
        n_checks++;
        if (actual !== expected) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, actual, expected, $time);
        end
    endtask

    function automatic int model_ready();
        return (m_beat == NB - 1 && m_q_data.size() == DEPTH) ? 0 : 1;
    endfunction

    // One clock cycle: drive inputs, check readiness, advance model, check outputs.
    task automatic step(input logic v, input logic [IOW-1:0] d, input logic fl,
                        input logic rr, input logic rst);
        int rdy;
        @(negedge clk);
        input_valid = v;
        input_data  = d;
        flush       = fl;
        round_ready = rr;
        reset       = rst;
        #1;
        rdy = model_ready();
        if (m_known) check_eq("input_ready", input_ready, rdy);
        @(posedge clk);
        #1;
        if (rst) begin
            m_beat = 0; m_rpos = 0; m_acc = 0; m_frames = 0;
            m_q_data.delete(); m_q_idx.delete();
            m_show_data = 0; m_show_idx = 0;
            m_known = 1'b1;
        end else begin
            if (rr && m_q_data.size() > 0) begin
                void'(m_q_data.pop_front());
                void'(m_q_idx.pop_front());
            end
            if (fl) begin
                m_beat = 0; m_rpos = 0; m_acc = 0;
            end else if (v && rdy == 1) begin
                m_acc = m_acc | (int'(d) << (m_beat * IOW));
                if (m_beat == NB - 1) begin
                    m_q_data.push_back(m_acc & ((1 << RB) - 1));
                    m_q_idx.push_back(m_rpos);
                    if (m_rpos == GU - 1) m_frames = (m_frames + 1) % 65536;
                    m_rpos = (m_rpos + 1) % GU;
                    m_beat = 0;
                    m_acc  = 0;
                end else begin
                    m_beat++;
                end
            end
            if (m_q_data.size() > 0) begin
                m_show_data = m_q_data[0];
                m_show_idx  = m_q_idx[0];
            end
        end
        if (m_known) begin
            check_eq("round_valid", round_valid, (m_q_data.size() > 0) ? 1 : 0);
            check_eq("round_data",  round_data,  m_show_data);
            check_eq("round_index", round_index, m_show_idx);
            check_eq("round_last",  round_last,  (m_show_idx == GU - 1) ? 1 : 0);
            check_eq("occupancy",   occupancy,   m_q_data.size());
            check_eq("frame_count", frame_count, m_frames);
        end
    endtask

    task automatic send_round(input int value, input logic rr);
        for (int b = 0; b < NB; b++) begin
            step(1'b1, IOW'((value >> (b * IOW)) & ((1 << IOW) - 1)), 1'b0, rr, 1'b0);
        end
    endtask

    initial begin
        input_valid = 1'b0;
        input_data  = '0;
        flush       = 1'b0;
        round_ready = 1'b0;
        reset       = 1'b1;

        step(1'b0, '0, 1'b0, 1'b0, 1'b1);
        step(1'b0, '0, 1'b0, 1'b0, 1'b1);
        check_eq("reset_ready", input_ready, 1);

        // Three-beat round with a dropped top bit.
        step(1'b1, 3'b101, 1'b0, 1'b0, 1'b0);
        step(1'b1, 3'b011, 1'b0, 1'b0, 1'b0);
        step(1'b1, 3'b110, 1'b0, 1'b0, 1'b0);
        check_eq("tp_data", round_data, 8'h9D);
        check_eq("tp_idx",  round_index, 0);
        step(1'b0, '0, 1'b0, 1'b1, 1'b0);

        // Flush drops a partial round and a concurrent beat, restarts the frame.
        step(1'b1, 3'b111, 1'b0, 1'b0, 1'b0);
        step(1'b1, 3'b111, 1'b1, 1'b0, 1'b0);
        check_eq("fl_occ", occupancy, 0);
        step(1'b1, 3'b001, 1'b0, 1'b0, 1'b0);
        step(1'b1, 3'b010, 1'b0, 1'b0, 1'b0);
        step(1'b1, 3'b100, 1'b0, 1'b0, 1'b0);
        check_eq("fl_data", round_data, 8'h11);
        check_eq("fl_idx",  round_index, 0);
        step(1'b0, '0, 1'b0, 1'b1, 1'b0);

        // Backpressure: four rounds fill the buffer, fifth round stalls on its final beat.
        step(1'b0, '0, 1'b0, 1'b0, 1'b1);
        for (int r = 0; r < 4; r++) send_round(16 + r * 37, 1'b0);
        check_eq("bp_occ", occupancy, 4);
        step(1'b1, 3'b010, 1'b0, 1'b0, 1'b0);
        step(1'b1, 3'b001, 1'b0, 1'b0, 1'b0);
        check_eq("bp_ready_low", input_ready, 0);
        step(1'b1, 3'b111, 1'b0, 1'b0, 1'b0);
        step(1'b1, 3'b111, 1'b0, 1'b1, 1'b0);
        check_eq("bp_ready_back", input_ready, 1);
        check_eq("bp_occ_pop", occupancy, 3);
        step(1'b1, 3'b111, 1'b0, 1'b0, 1'b0);
        check_eq("bp_occ_full", occupancy, 4);
        check_eq("bp_frames", frame_count, 1);

        // Reset with rounds buffered mid-frame.
        step(1'b1, 3'b000, 1'b0, 1'b0, 1'b0);
        step(1'b0, '0, 1'b0, 1'b0, 1'b1);
        check_eq("rst_occ",   occupancy, 0);
        check_eq("rst_valid", round_valid, 0);
        check_eq("rst_frame", frame_count, 0);
        check_eq("rst_ready", input_ready, 1);

        // Randomized traffic with varying consumer pressure.
        for (int ph = 0; ph < 6; ph++) begin
            int p_ready;
            p_ready = (ph % 3 == 0) ? 10 : ((ph % 3 == 1) ? 50 : 95);
            for (int c = 0; c < 300; c++) begin
                step(($urandom_range(0, 99) < 75) ? 1'b1 : 1'b0,
                     IOW'($urandom_range(0, (1 << IOW) - 1)),
                     ($urandom_range(0, 99) < 4) ? 1'b1 : 1'b0,
                     ($urandom_range(0, 99) < p_ready) ? 1'b1 : 1'b0,
                     ($urandom_range(0, 999) < 5) ? 1'b1 : 1'b0);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
